// File: rtl/flits_sender_pkg.sv
// flits_sender_pkg
//   Shared sizing, flit-type encodings, FSM state type and small helpers for
//   the flits_sender injection block. Flit type lives in the low nibble of
//   each flit; a head flit may be encoded as 0 or 4.
package flits_sender_pkg;

  localparam int MAX_PACKET_LENGHT = 8;
  localparam int FLIT_WIDTH        = 8;
  localparam int FLIT_TYPE_WIDTH   = 4;
  localparam int N_BITS_POINTER    = $clog2(MAX_PACKET_LENGHT);

  localparam logic [FLIT_TYPE_WIDTH-1:0] FLIT_TYPE_HEAD      = 4'h0;
  localparam logic [FLIT_TYPE_WIDTH-1:0] FLIT_TYPE_HEAD_ALT  = 4'h4;
  localparam logic [FLIT_TYPE_WIDTH-1:0] FLIT_TYPE_BODY      = 4'h1;
  localparam logic [FLIT_TYPE_WIDTH-1:0] FLIT_TYPE_TAIL      = 4'h2;
  localparam logic [FLIT_TYPE_WIDTH-1:0] FLIT_TYPE_HEAD_TAIL = 4'h3;

  typedef enum logic {IDLE, SEND} state_t;
  typedef logic [N_BITS_POINTER-1:0] ptr_t;

  // Index of the highest set bit of a contiguous valid-flit mask (len-1).
  function automatic ptr_t last_index(input logic [MAX_PACKET_LENGHT-1:0] sel);
    ptr_t idx;
    idx = '0;
    for (int i = 0; i < MAX_PACKET_LENGHT; i++)
      if (sel[i]) idx = ptr_t'(i);
    return idx;
  endfunction

  function automatic logic is_head(input logic [FLIT_TYPE_WIDTH-1:0] t);
    return (t == FLIT_TYPE_HEAD) || (t == FLIT_TYPE_HEAD_ALT);
  endfunction

endpackage

// File: rtl/flits_sender_credit_counter.sv
// flits_sender_credit_counter
//   Saturating up/down credit counter, reset to N_CREDITS (the downstream
//   buffer depth). inc and dec in the same cycle cancel out; an inc at the
//   full count is dropped.
// Ports:
//   clk, rst (async, active-low)
//   inc     : one downstream slot freed
//   dec     : one flit emitted (only asserted while nonzero)
//   nonzero : at least one credit available (from the registered count)
module flits_sender_credit_counter #(
  parameter int N_CREDITS     = 8,
  localparam int N_BITS_CREDIT = $clog2(N_CREDITS + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic nonzero
);

  logic [N_BITS_CREDIT-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= N_BITS_CREDIT'(N_CREDITS);
    end else begin
      case ({inc, dec})
        2'b10: if (count_reg != N_BITS_CREDIT'(N_CREDITS))
                 count_reg <= count_reg + N_BITS_CREDIT'(1);
        2'b01: count_reg <= count_reg - N_BITS_CREDIT'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Derived from the registered count, so a credit returned at zero only
  // enables emission in the following cycle.
  assign nonzero = (count_reg != '0);

endmodule

// File: rtl/flits_sender.sv
// flits_sender
//   Injection-side packet serializer between the message packetizer and a
//   router input port. Accepts a whole packet via request/grant, then emits
//   one flit per cycle under credit-based flow control. The head flit also
//   waits for free_signal_i.
// Optional build macro: FLITS_SENDER_TYPE_CHECK_EN adds proto_err_o and drops
//   packets whose flit-type framing is malformed (they are still granted).
// Ports:
//   clk, rst (async, active-low)
//   in_link_i, in_sel_i       : packet flits and contiguous valid mask
//   r_pkt_to_send_i           : level request, held until granted
//   g_pkt_to_send_o           : registered one-cycle grant
//   out_link_o, is_valid_o    : flit to router and its valid
//   credit_signal_i           : one-cycle credit return pulse
//   free_signal_i             : downstream accepts a new head flit
//   busy_o                    : a packet is held or being sent
//   proto_err_o (optional)    : sticky framing error flag
module flits_sender
  import flits_sender_pkg::*;
#(
  parameter int N_CREDITS = MAX_PACKET_LENGHT
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] in_link_i,
  input  logic [MAX_PACKET_LENGHT-1:0]            in_sel_i,
  input  logic                                    r_pkt_to_send_i,
  output logic                                    g_pkt_to_send_o,
  output logic [FLIT_WIDTH-1:0]                   out_link_o,
  output logic                                    is_valid_o,
  input  logic                                    credit_signal_i,
  input  logic                                    free_signal_i,
`ifdef FLITS_SENDER_TYPE_CHECK_EN
  output logic                                    proto_err_o,
`endif
  output logic                                    busy_o
);

  state_t                                state_reg, state_next;
  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] pkt_reg;
  ptr_t                                  ptr_reg, ptr_next;
  ptr_t                                  last_reg;
  logic                                  grant_reg, grant_next;
  logic [FLIT_WIDTH-1:0]                 out_link_reg;
  logic                                  valid_reg;
  logic                                  busy_reg;
  logic                                  load, emit, credit_nz, pkt_ok, type_ok;
  ptr_t                                  sel_last;

  assign sel_last = last_index(in_sel_i);

`ifdef FLITS_SENDER_TYPE_CHECK_EN
  logic [FLIT_TYPE_WIDTH-1:0] first_type, last_type;
  logic                       proto_err_reg;

  assign first_type = in_link_i[FLIT_TYPE_WIDTH-1:0];
  assign last_type  = in_link_i[sel_last*FLIT_WIDTH +: FLIT_TYPE_WIDTH];
  // A single-flit packet must be head_tail; longer ones need a head-capable
  // first flit and a tail-capable last flit.
  assign type_ok = (sel_last == '0) ? (first_type == FLIT_TYPE_HEAD_TAIL) :
                   ((is_head(first_type) || first_type == FLIT_TYPE_HEAD_TAIL) &&
                    (last_type == FLIT_TYPE_TAIL || last_type == FLIT_TYPE_HEAD_TAIL));
  assign proto_err_o = proto_err_reg;
`else
  assign type_ok = 1'b1;
`endif

  // An empty mask is granted but never latched.
  assign pkt_ok = (|in_sel_i) && type_ok;

  flits_sender_credit_counter #(.N_CREDITS(N_CREDITS)) u_credit (
    .clk     (clk),
    .rst     (rst),
    .inc     (credit_signal_i),
    .dec     (emit),
    .nonzero (credit_nz)
  );

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    grant_next = 1'b0;
    load       = 1'b0;
    emit       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (r_pkt_to_send_i) begin
          grant_next = 1'b1;
          if (pkt_ok) begin
            load       = 1'b1;
            state_next = SEND;
          end
        end
      end
      SEND: begin
        // free_signal_i gates only the head flit.
        if (credit_nz && (ptr_reg != '0 || free_signal_i)) begin
          emit = 1'b1;
          if (ptr_reg == last_reg) begin
            // Last flit: a pending request is granted now so the next head
            // can follow without a bubble.
            if (r_pkt_to_send_i) begin
              grant_next = 1'b1;
              if (pkt_ok) load = 1'b1;
              else        state_next = IDLE;
            end else begin
              state_next = IDLE;
            end
          end else begin
            ptr_next = ptr_reg + ptr_t'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (load) ptr_next = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      last_reg     <= '0;
      pkt_reg      <= '0;
      grant_reg    <= 1'b0;
      out_link_reg <= '0;
      valid_reg    <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      valid_reg <= emit;
      busy_reg  <= (state_next == SEND);
      if (emit) out_link_reg <= pkt_reg[ptr_reg*FLIT_WIDTH +: FLIT_WIDTH];
      if (load) begin
        pkt_reg  <= in_link_i;
        last_reg <= sel_last;
      end
    end
  end

`ifdef FLITS_SENDER_TYPE_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      proto_err_reg <= 1'b0;
    else if (grant_next && (|in_sel_i) && !type_ok)
      proto_err_reg <= 1'b1;
  end
`endif

  assign g_pkt_to_send_o = grant_reg;
  assign out_link_o      = out_link_reg;
  assign is_valid_o      = valid_reg;
  assign busy_o          = busy_reg;

endmodule

// File: tb/tb_flits_sender.sv
// tb_flits_sender
//   Directed bench for flits_sender (default N_CREDITS = 8). Inputs are driven
//   1 time unit after each rising edge, outputs are sampled at the same point.
//   Build with FLITS_SENDER_TYPE_CHECK_EN to exercise the framing check.
module tb_flits_sender;
  import flits_sender_pkg::*;

  logic                                    clk = 1'b0;
  logic                                    rst;
  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] in_link_i;
  logic [MAX_PACKET_LENGHT-1:0]            in_sel_i;
  logic                                    r_pkt_to_send_i;
  logic                                    g_pkt_to_send_o;
  logic [FLIT_WIDTH-1:0]                   out_link_o;
  logic                                    is_valid_o;
  logic                                    credit_signal_i;
  logic                                    free_signal_i;
  logic                                    busy_o;
`ifdef FLITS_SENDER_TYPE_CHECK_EN
  logic                                    proto_err_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  flits_sender dut (
    .clk             (clk),
    .rst             (rst),
    .in_link_i       (in_link_i),
    .in_sel_i        (in_sel_i),
    .r_pkt_to_send_i (r_pkt_to_send_i),
    .g_pkt_to_send_o (g_pkt_to_send_o),
    .out_link_o      (out_link_o),
    .is_valid_o      (is_valid_o),
    .credit_signal_i (credit_signal_i),
    .free_signal_i   (free_signal_i),
`ifdef FLITS_SENDER_TYPE_CHECK_EN
    .proto_err_o     (proto_err_o),
`endif
    .busy_o          (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a packet, hold the request across one edge, expect the grant.
  task automatic grant_pkt(input string tag, input logic [63:0] flits, input logic [7:0] sel,
                           input logic exp_busy);
    in_link_i       = flits;
    in_sel_i        = sel;
    r_pkt_to_send_i = 1'b1;
    tick();
    check({tag, "_grant"}, g_pkt_to_send_o, 1);
    check({tag, "_busy"}, busy_o, exp_busy);
    r_pkt_to_send_i = 1'b0;
  endtask

  task automatic expect_flit(input string tag, input logic [7:0] f);
    tick();
    check({tag, "_valid"}, is_valid_o, 1);
    check({tag, "_data"}, out_link_o, f);
  endtask

  task automatic expect_idle(input string tag, input logic [7:0] hold);
    tick();
    check({tag, "_valid"}, is_valid_o, 0);
    check({tag, "_hold"}, out_link_o, hold);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b0;
    in_link_i       = '0;
    in_sel_i        = '0;
    r_pkt_to_send_i = 1'b0;
    credit_signal_i = 1'b0;
    free_signal_i   = 1'b1;
    #2;
    check("rst_grant", g_pkt_to_send_o, 0);
    check("rst_valid", is_valid_o, 0);
    check("rst_data", out_link_o, 0);
    check("rst_busy", busy_o, 0);
    tick();
    rst = 1'b1;
    tick();

    // Five-flit packet, credits 8 -> 3.
    grant_pkt("p5", 64'h0000_00D2_C1B1_A104, 8'b0001_1111, 1);
    expect_flit("p5_f0", 8'h04);
    check("p5_no_regrant", g_pkt_to_send_o, 0);
    expect_flit("p5_f1", 8'hA1);
    expect_flit("p5_f2", 8'hB1);
    expect_flit("p5_f3", 8'hC1);
    expect_flit("p5_f4", 8'hD2);
    check("p5_done_busy", busy_o, 0);
    expect_idle("p5_after", 8'hD2);

    // Four-flit packet with 3 credits: stalls before the tail.
    grant_pkt("p4", 64'h0000_0000_5241_3104, 8'b0000_1111, 1);
    expect_flit("p4_f0", 8'h04);
    expect_flit("p4_f1", 8'h31);
    expect_flit("p4_f2", 8'h41);
    expect_idle("p4_stall0", 8'h41);
    expect_idle("p4_stall1", 8'h41);
    check("p4_stall_busy", busy_o, 1);
    credit_signal_i = 1'b1;
    expect_idle("p4_credit_edge", 8'h41);
    credit_signal_i = 1'b0;
    expect_flit("p4_f3", 8'h52);
    check("p4_done_busy", busy_o, 0);

    // Refill to full.
    credit_signal_i = 1'b1;
    repeat (10) tick();
    credit_signal_i = 1'b0;

    // Back-to-back: second request held during the first packet's tail cycle.
    grant_pkt("b1", 64'h0000_0000_0062_5104, 8'b0000_0111, 1);
    expect_flit("b1_f0", 8'h04);
    expect_flit("b1_f1", 8'h51);
    in_link_i       = 64'h0000_0000_0000_8214;
    in_sel_i        = 8'b0000_0011;
    r_pkt_to_send_i = 1'b1;
    expect_flit("b1_f2", 8'h62);
    check("b2_grant_on_tail", g_pkt_to_send_o, 1);
    check("b2_busy", busy_o, 1);
    r_pkt_to_send_i = 1'b0;
    expect_flit("b2_f0", 8'h14);
    expect_flit("b2_f1", 8'h82);
    check("b2_done_busy", busy_o, 0);

    // Credits now 3; credit pulse concurrent with emit at count 1 keeps 1.
    grant_pkt("c3", 64'h0000_0000_00A2_9104, 8'b0000_0111, 1);
    expect_flit("c3_f0", 8'h04);
    expect_flit("c3_f1", 8'h91);
    credit_signal_i = 1'b1;
    expect_flit("c3_f2", 8'hA2);
    credit_signal_i = 1'b0;
    grant_pkt("s1", 64'h0000_0000_0000_0003, 8'b0000_0001, 1);
    expect_flit("s1_f0", 8'h03);
    grant_pkt("s2", 64'h0000_0000_0000_0013, 8'b0000_0001, 1);
    expect_idle("s2_stall0", 8'h03);
    expect_idle("s2_stall1", 8'h03);
    credit_signal_i = 1'b1;
    expect_idle("s2_credit_edge", 8'h03);
    credit_signal_i = 1'b0;
    expect_flit("s2_f0", 8'h13);

    // Saturation: 10 pulses from 0 leave 8; an 8-flit packet drains to 0.
    credit_signal_i = 1'b1;
    repeat (10) tick();
    credit_signal_i = 1'b0;
    grant_pkt("p8", 64'h7261_5141_3121_1104, 8'hFF, 1);
    expect_flit("p8_f0", 8'h04);
    expect_flit("p8_f1", 8'h11);
    expect_flit("p8_f2", 8'h21);
    expect_flit("p8_f3", 8'h31);
    expect_flit("p8_f4", 8'h41);
    expect_flit("p8_f5", 8'h51);
    expect_flit("p8_f6", 8'h61);
    expect_flit("p8_f7", 8'h72);
    grant_pkt("sat", 64'h0000_0000_0000_0023, 8'b0000_0001, 1);
    expect_idle("sat_stall0", 8'h72);
    expect_idle("sat_stall1", 8'h72);
    expect_idle("sat_stall2", 8'h72);
    check("sat_busy", busy_o, 1);

    // Reset mid-packet drops it and restores credits.
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_valid", is_valid_o, 0);
    check("mid_rst_data", out_link_o, 0);
    tick();
    rst = 1'b1;

    // free low for 3 cycles after grant holds back the head only.
    free_signal_i = 1'b0;
    grant_pkt("fr", 64'h0000_0000_0000_A204, 8'b0000_0011, 1);
    expect_idle("fr_wait0", 8'h00);
    expect_idle("fr_wait1", 8'h00);
    expect_idle("fr_wait2", 8'h00);
    free_signal_i = 1'b1;
    expect_flit("fr_f0", 8'h04);
    free_signal_i = 1'b0;
    expect_flit("fr_f1", 8'hA2);
    check("fr_done_busy", busy_o, 0);
    free_signal_i = 1'b1;

    // Empty mask: granted, discarded.
    grant_pkt("empty", 64'h0000_0000_0000_0003, 8'b0000_0000, 0);
    expect_idle("empty_after", 8'hA2);
    check("empty_grant_drop", g_pkt_to_send_o, 0);

`ifdef FLITS_SENDER_TYPE_CHECK_EN
    check("perr_initial", proto_err_o, 0);
    grant_pkt("bad", 64'h0000_0000_0000_A104, 8'b0000_0011, 0);
    check("bad_perr", proto_err_o, 1);
    expect_idle("bad_drop0", 8'hA2);
    expect_idle("bad_drop1", 8'hA2);
    check("bad_perr_sticky", proto_err_o, 1);
    rst = 1'b0;
    #1;
    check("bad_perr_rst", proto_err_o, 0);
    tick();
    rst = 1'b1;
`else
    grant_pkt("raw", 64'h0000_0000_0000_A104, 8'b0000_0011, 1);
    expect_flit("raw_f0", 8'h04);
    expect_flit("raw_f1", 8'hA1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flits_sender.md
Name: flits_sender

Overview:
- Injection-side counterpart of flits_buffer: sits between the WB-to-NoC message packetizer and the Router input port.
- Accepts one whole packet (up to `MAX_PACKET_LENGHT flits) through a request/grant handshake.
- Serializes the packet onto the router link at one flit per cycle, using credit-based flow control.
- Respects the downstream free/credit signals, which are the same ones flits_buffer drives on the receive side.

Parameters:
- N_BITS_POINTER, clog2(`MAX_PACKET_LENGHT), index width of the internal flit slot pointer.
- N_CREDITS, `MAX_PACKET_LENGHT, downstream buffer depth and reset value of the credit counter.
- N_BITS_CREDIT, clog2(N_CREDITS+1), credit counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- in_link_i  in  `MAX_PACKET_LENGHT*`FLIT_WIDTH  packet; flit k at bits [k*`FLIT_WIDTH +: `FLIT_WIDTH].
- in_sel_i  in  `MAX_PACKET_LENGHT  valid flit mask, contiguous from bit 0.
- r_pkt_to_send_i  in  1  packet request; level signal, held until granted.
- g_pkt_to_send_o  out  1  one-cycle grant; packet is latched on this cycle's edge.
- out_link_o  out  `FLIT_WIDTH  flit to Router.
- is_valid_o  out  1  out_link_o carries a valid flit.
- credit_signal_i  in  1  one-cycle pulse; one downstream slot freed.
- free_signal_i  in  1  downstream buffer can accept a new head flit.
- busy_o  out  1  packet is held or being sent.

Behaviour:
- Reset values: g_pkt_to_send_o=0, out_link_o=0, is_valid_o=0, busy_o=0, credit counter=N_CREDITS, FSM=IDLE, stored packet cleared.
- All outputs are registered.
- FSM states are IDLE and SEND.
- IDLE:
  - If r_pkt_to_send_i=1, assert g_pkt_to_send_o combinationally-registered for one cycle.
  - On that edge, latch in_link_i and in_sel_i, set len = index of highest set sel bit + 1, set ptr=0, go to SEND, set busy_o=1.
  - If in_sel_i=0: still grant, discard the packet, stay in IDLE.
- SEND, flit ptr is emitted when both hold:
  - credit counter > 0;
  - free_signal_i=1, checked only when ptr=0 (head).
- When a flit is emitted: out_link_o=flit[ptr], is_valid_o=1 on the next edge, ptr++, credit--.
- When the flit is not emitted: is_valid_o=0 and out_link_o holds its last value.
- Latency: grant edge T → head flit valid at T+1 at the earliest.
- Last flit (ptr=len-1) emitted:
  - If r_pkt_to_send_i=1 in the same cycle, grant and latch the next packet and stay in SEND (back-to-back, no bubble).
  - Otherwise go to IDLE and clear busy_o.
- Credit counter:
  - +1 on credit_signal_i, -1 on flit emit; both in the same cycle → unchanged.
  - Saturates at N_CREDITS; a credit arriving when full is ignored.
  - A credit arriving when the count is 0 enables emission in the following cycle, not the same cycle.
- No grant is issued while in SEND except on the last-flit cycle.
- Flits are transmitted unmodified; type lives in the low nibble (0/4 head, 1 body, 2 tail, 3 head_tail).
- Reset asserted mid-packet:
  - The packet is dropped immediately and credits are restored to N_CREDITS.
  - The downstream buffer is expected to be reset by the same signal.

Optional Feature:
- FLITS_SENDER_TYPE_CHECK_EN, when defined:
  - Adds output proto_err_o (1 bit, reset 0), sticky until reset.
  - Set when a latched packet's flit 0 type is not head/head_tail, when its last flit is not tail/head_tail, or when len=1 with a type other than head_tail.
  - The offending packet is still granted but discarded (no flits sent).
- When undefined: no port and no check; every packet is sent as given.

Decomposition:
- Into NIC-defines.v: FLIT_TYPE_HEAD, FLIT_TYPE_BODY, FLIT_TYPE_TAIL, FLIT_TYPE_HEAD_TAIL, FLIT_TYPE_WIDTH.
- clog2 comes from NIC_utils.vh.
- One natural sub-module: flits_sender_credit_counter (saturating up/down counter with a nonzero flag).

Test Plan:
- Reset, then request with packet {D2,C1,B1,A1,04}, sel=5'b11111, free=1, no credits returned → grant at T; flits 04,A1,B1,C1,D2 valid on T+1..T+5; credit count ends at N_CREDITS-5.
- N_CREDITS=2, 4-flit packet, no credit pulses → 2 flits sent, then is_valid_o=0 stalls. Credit pulse at cycle X → third flit appears at X+2.
- free_signal_i=0 for 3 cycles after grant → no head flit; head appears the cycle after free rises.
- Two requests queued: second request held high during first packet's tail cycle → second grant on the tail edge; second head follows the first tail with no idle cycle.
- Credit pulse concurrent with emit at count 1 → count stays 1. Credit pulse at count N_CREDITS → stays N_CREDITS.
- With FLITS_SENDER_TYPE_CHECK_EN defined, packet {A1,04}, sel=2'b11 (last flit not tail) → grant, no valid flits, proto_err_o=1 until rst low.
